// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared bus types plus coherence controller state and request classes.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [3:0] {IDLE, IFETCH, WB0, WB1, SNOOP, C2C0, C2C1, RAM0, RAM1} cc_state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_WB, CLS_FILL, CLS_IF} req_cls_t;
    localparam int CPUS     = 2;
    localparam int BLKWORDS = 2;
endpackage

// File: rtl/cc_arbiter.sv
// cc_arbiter: picks the highest request class, then one CPU within it.
// CC_ROUND_ROBIN_EN gives ties to the CPU not granted last; otherwise CPU0 wins ties.
module cc_arbiter
    import cpu_types_pkg::*;
(
    input  logic [1:0] wb,
    input  logic [1:0] fill,
    input  logic [1:0] ifetch,
`ifdef CC_ROUND_ROBIN_EN
    input  logic       last,
`endif
    output logic [1:0] gnt,
    output req_cls_t   cls
);
    logic [1:0] v;
    logic       pick;
    always_comb begin
        cls = |wb ? CLS_WB : |fill ? CLS_FILL : |ifetch ? CLS_IF : CLS_NONE;
        v = |wb ? wb : |fill ? fill : ifetch;
`ifdef CC_ROUND_ROBIN_EN
        pick = &v ? ~last : v[1];
`else
        pick = ~v[0];
`endif
        gnt = cls == CLS_NONE ? 2'b00 : (pick ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/coherence_controller.sv
// coherence_controller: two-cache MSI bus controller arbitrating one RAM port.
// Optional CC_ROUND_ROBIN_EN: round-robin tie breaking inside a request class.
module coherence_controller
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        iREN,
    input  logic [1:0]        dREN,
    input  logic [1:0]        dWEN,
    input  word_t [1:0]       iaddr,
    input  word_t [1:0]       daddr,
    input  word_t [1:0]       dstore,
    input  logic [1:0]        ccwrite,
    input  logic [1:0]        cctrans,
    input  word_t             ramload,
    input  ramstate_t         ramstate,
    output logic [1:0]        iwait,
    output logic [1:0]        dwait,
    output word_t [1:0]       iload,
    output word_t [1:0]       dload,
    output logic [1:0]        ccwait,
    output logic [1:0]        ccinv,
    output word_t [1:0]       ccsnoopaddr,
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore
);
    cc_state_t  state, nstate;
    req_cls_t   cls;
    logic [1:0] gnt;
    logic       g, p, acc;
`ifdef CC_ROUND_ROBIN_EN
    logic       last;
`endif

    assign p   = ~g;
    assign acc = ramstate == ACCESS;

    cc_arbiter u_arb (
        .wb     (dWEN & ~dREN & cctrans),
        .fill   (dREN & cctrans),
        .ifetch (iREN),
`ifdef CC_ROUND_ROBIN_EN
        .last   (last),
`endif
        .gnt    (gnt),
        .cls    (cls)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= 1'b0;
`ifdef CC_ROUND_ROBIN_EN
            last  <= 1'b1;
`endif
        end else begin
            state <= nstate;
            if (state == IDLE && cls != CLS_NONE) begin
                g    <= gnt[1];
`ifdef CC_ROUND_ROBIN_EN
                last <= gnt[1];
`endif
            end
        end
    end

    always_comb begin
        nstate      = state;
        iwait       = 2'b11;
        dwait       = 2'b11;
        iload       = '0;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        // the snooped peer stays blocked from the snoop until the fill finishes
        if (state inside {SNOOP, C2C0, C2C1, RAM0, RAM1}) begin
            ccwait[p]      = 1'b1;
            ccsnoopaddr[p] = daddr[g];
            ccinv[p]       = ccwrite[g];
        end
        case (state)
            IDLE: nstate = cls == CLS_WB ? WB0 : cls == CLS_FILL ? SNOOP : cls == CLS_IF ? IFETCH : IDLE;
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g];
                if (acc) begin
                    iwait[g] = 1'b0;
                    iload[g] = ramload;
                    nstate   = IDLE;
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                if (acc) begin
                    dwait[g] = 1'b0;
                    nstate   = state == WB0 && dWEN[g] ? WB1 : IDLE;
                end
            end
            SNOOP: nstate = ccwrite[p] && dWEN[p] ? C2C0 : RAM0;
            C2C0, C2C1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[p];
                ramstore = dstore[p];
                dload[g] = dstore[p];
                if (acc) begin
                    dwait    = 2'b00;
                    nstate   = state == C2C0 && dREN[g] && dWEN[p] ? C2C1 : IDLE;
                end
            end
            RAM0, RAM1: begin
                ramREN  = 1'b1;
                ramaddr = daddr[g];
                if (acc) begin
                    dwait[g] = 1'b0;
                    dload[g] = ramload;
                    nstate   = state == RAM0 && dREN[g] ? RAM1 : IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_controller.sv
// tb_coherence_controller: directed checks of arbitration, snoops, c2c transfers and reset.
module tb_coherence_controller;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [1:0] iaddr, daddr, dstore;
    word_t       ramload;
    ramstate_t   ramstate;
    logic [1:0]  iwait, dwait, ccwait, ccinv;
    word_t [1:0] iload, dload, ccsnoopaddr;
    logic        ramREN, ramWEN;
    word_t       ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    coherence_controller dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans),
        .ramload(ramload), .ramstate(ramstate), .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore)
    );

    always #5 CLK = ~CLK;

    // RAM model: two-cycle latency (BUSY then ACCESS), mem[a] = 0xC0DE0000 + byte address
    word_t mem [256];
    logic  cnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i * 4);
        end else begin
            cnt <= (ramREN | ramWEN) && !cnt;
            if (ramWEN && cnt) mem[ramaddr[9:2]] <= ramstore;
        end
    end
    assign ramstate = (ramREN | ramWEN) ? (cnt ? ACCESS : BUSY) : FREE;
    assign ramload  = mem[ramaddr[9:2]];

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // kind 0 waits for iwait[cpu] low, kind 1 for dwait[cpu] low
    task automatic wait_low(input string tag, input int kind, input int cpu);
        for (int i = 0; i < 20; i++) begin
            step();
            if ((kind == 0 ? iwait[cpu] : dwait[cpu]) == 1'b0) return;
        end
        total++;
        bad++;
        $error("FAIL %s: timeout got wait=1 want wait=0", tag);
    endtask

    task automatic idle_inputs();
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        step();
        step();
        nRST = 1'b1;
    endtask

    initial begin
        int got;
        do_reset();
        nRST = 1'b0;
        #1;
        chk("rst iwait", iwait, 2'b11);
        chk("rst dwait", dwait, 2'b11);
        chk("rst ccwait", ccwait, 2'b00);
        chk("rst ccinv", ccinv, 2'b00);
        chk("rst ram strobes", {ramREN, ramWEN}, 2'b00);
        chk("rst ramaddr", ramaddr, 0);
        chk("rst ramstore", ramstore, 0);
        chk("rst snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 0);
        chk("rst loads", iload[0] | iload[1] | dload[0] | dload[1], 0);
        step();
        nRST = 1'b1;
        step();

        // 1: single ifetch
        iREN = 2'b01; iaddr[0] = 32'h40;
        step();
        chk("t1 busy iwait", iwait, 2'b11);
        chk("t1 ramREN", ramREN, 1'b1);
        chk("t1 ramaddr", ramaddr, 32'h40);
        wait_low("t1 iwait", 0, 0);
        chk("t1 iload", iload[0], 32'hC0DE_0040);
        iREN = 2'b00;
        step();
        chk("t1 one cycle", iwait, 2'b11);

        // 2: fill from RAM, peer clean
        dREN = 2'b10; cctrans = 2'b10; daddr[1] = 32'h80;
        step();
        chk("t2 ccwait", ccwait, 2'b01);
        chk("t2 snoopaddr", ccsnoopaddr[0], 32'h80);
        chk("t2 ccinv", ccinv, 2'b00);
        chk("t2 snoop dwait", dwait, 2'b11);
        for (int w = 0; w < BLKWORDS; w++) begin
            wait_low("t2 dwait", 1, 1);
            chk("t2 dload", dload[1], 32'hC0DE_0080 + 32'(w * 4));
            chk("t2 ccwait held", ccwait, 2'b01);
            chk("t2 ramREN", {ramREN, ramWEN}, 2'b10);
            step();
            chk("t2 dwait pulse", dwait[1], 1'b1);
            if (w == 0) daddr[1] = 32'h84;
            else begin dREN = '0; cctrans = '0; end
        end
        chk("t2 released", ccwait, 2'b00);

        // 3: BusRdX, peer holds block in M -> cache-to-cache with writeback
        dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'hC0;
        step();
        chk("t3 ccinv", ccinv, 2'b10);
        chk("t3 ccwait", ccwait, 2'b10);
        chk("t3 snoopaddr", ccsnoopaddr[1], 32'hC0);
        ccwrite[1] = 1'b1; dWEN = 2'b10; daddr[1] = 32'hC0; dstore[1] = 32'hDEAD;
        wait_low("t3 dwait0", 1, 0);
        chk("t3 dload w0", dload[0], 32'hDEAD);
        chk("t3 peer dwait w0", dwait[1], 1'b0);
        chk("t3 ramWEN w0", {ramREN, ramWEN}, 2'b01);
        chk("t3 ramstore w0", ramstore, 32'hDEAD);
        step();
        daddr[0] = 32'hC4; daddr[1] = 32'hC4; dstore[1] = 32'hBEEF;
        wait_low("t3 dwait0 w1", 1, 0);
        chk("t3 dload w1", dload[0], 32'hBEEF);
        chk("t3 peer dwait w1", dwait[1], 1'b0);
        step();
        idle_inputs();
        chk("t3 mem w0", mem[8'h30], 32'hDEAD);
        chk("t3 mem w1", mem[8'h31], 32'hBEEF);
        chk("t3 released", ccwait, 2'b00);

        // 4: simultaneous ifetches from both CPUs
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (iwait != 2'b11) begin
                    got = iwait[0] == 1'b0 ? 0 : 1;
                    break;
                end
            end
            if (got < 0) begin
                total++;
                bad++;
                $error("FAIL t4 timeout: got iwait=11 want one low");
            end else begin
`ifdef CC_ROUND_ROBIN_EN
                chk("t4 grant", 32'(got), 32'(k % 2));
`else
                chk("t4 grant", 32'(got), 0);
`endif
                chk("t4 iload", iload[got], got == 1 ? 32'hC0DE_0200 : 32'hC0DE_0100);
            end
            if (k == 3) iREN = 2'b00;
        end

        // 5: writeback beats a concurrent ifetch
        step();
        dWEN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h300; dstore[0] = 32'h1111_1111;
        iREN = 2'b10; iaddr[1] = 32'h40;
        wait_low("t5 wb0", 1, 0);
        chk("t5 ifetch held w0", iwait, 2'b11);
        chk("t5 ramWEN", {ramREN, ramWEN}, 2'b01);
        step();
        daddr[0] = 32'h304; dstore[0] = 32'h2222_2222;
        wait_low("t5 wb1", 1, 0);
        chk("t5 ifetch held w1", iwait, 2'b11);
        step();
        dWEN = '0; cctrans = '0;
        wait_low("t5 ifetch", 0, 1);
        chk("t5 iload", iload[1], 32'hC0DE_0040);
        chk("t5 mem w0", mem[8'hC0], 32'h1111_1111);
        chk("t5 mem w1", mem[8'hC1], 32'h2222_2222);
        iREN = '0;
        step();

        // 6: reset asserted during C2C1
        dREN = 2'b10; cctrans = 2'b10; daddr[1] = 32'h20;
        step();
        ccwrite[0] = 1'b1; dWEN = 2'b01; daddr[0] = 32'h20; dstore[0] = 32'h1234_5678;
        wait_low("t6 c2c0", 1, 1);
        chk("t6 dload", dload[1], 32'h1234_5678);
        step();
        chk("t6 in c2c1", {ramWEN, ccwait}, 3'b101);
        nRST = 1'b0;
        #1;
        chk("t6 rst strobes", {ramREN, ramWEN}, 2'b00);
        chk("t6 rst waits", {iwait, dwait}, 4'b1111);
        chk("t6 rst cc", {ccwait, ccinv}, 4'b0000);
        chk("t6 rst ramaddr", ramaddr, 0);
        chk("t6 rst dload", dload[1], 0);
        idle_inputs();
        step();
        nRST = 1'b1;
        step();
        chk("t6 idle after release", {ramREN, ramWEN, ccwait}, 4'b0000);
        iREN = 2'b10; iaddr[1] = 32'h8;
        wait_low("t6 ifetch", 0, 1);
        chk("t6 iload", iload[1], 32'hC0DE_0008);
        iREN = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
